stopwatch_ctrl: RTL and testbench

Mode controller for the mm:ss stopwatch counter chain.
- Runs a RUN / PAUSED / ADJUST state machine from the tick strobes, pause, sel and adj inputs.
- Issues single-cycle `sec_inc` / `min_inc` pulses to the synchronous-enable counter datapath. The datapath wraps each field 00..59 and has no internal sec→min carry. In RUN this block generates the carry; in ADJUST it suppresses it.
- Drives the blink qualifiers consumed by the display driver.

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/stopwatch_ctrl.sv | 148 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the mm:ss stopwatch: controller state encoding,
// adjust field select values and the counter field limit.
package stopwatch_pkg;

    // Controller modes
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    // Adjust field select encoding on the sel input
    localparam logic SEL_SEC = 1'b1;
    localparam logic SEL_MIN = 1'b0;

    // Largest value held by a seconds/minutes field before wrapping to 00
    localparam int unsigned SEC_MAX = 59;

    // Width of the adjust-rate divider (ADJ_DIV up to 15)
    localparam int unsigned ADJ_CNT_W = 4;

endpackage

// File: rtl/stopwatch_ctrl.sv
// Mode controller for the mm:ss stopwatch counter chain.
// Runs RUN / PAUSED / ADJUST from the tick strobes and user inputs, issues
// single-cycle increment pulses to the counter datapath (generating the
// sec->min carry in RUN, suppressing it in ADJUST) and drives the blink
// qualifiers for the display.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   tick_1hz    1 Hz single-cycle strobe
//   tick_2hz    2 Hz single-cycle strobe
//   pause_p     pause button pulse, toggles the pause flag
//   sel         adjust field select (1 = seconds, 0 = minutes)
//   adj         adjust mode request (level)
//   sec_at_max  seconds field currently at its maximum
//   sec_inc     registered seconds increment pulse
//   min_inc     registered minutes increment pulse
//   running     registered, high while in RUN
//   blink_sec   registered, seconds digits blanked this phase
//   blink_min   registered, minutes digits blanked this phase
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned ADJ_DIV        = 1,
    parameter bit          PAUSE_ON_RESET = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_1hz,
    input  logic tick_2hz,
    input  logic pause_p,
    input  logic sel,
    input  logic adj,
    input  logic sec_at_max,
    output logic sec_inc,
    output logic min_inc,
    output logic running,
    output logic blink_sec,
    output logic blink_min
);

    localparam state_t                 RESET_STATE = PAUSE_ON_RESET ? ST_PAUSED : ST_RUN;
    localparam logic [ADJ_CNT_W-1:0]   ADJ_LAST    = ADJ_CNT_W'(ADJ_DIV - 1);

    state_t               state;
    state_t               state_next;
    logic                 pause_flag;
    logic                 pause_flag_next;
    logic                 blink_phase;
    logic                 blink_phase_next;
    logic [ADJ_CNT_W-1:0] adj_cnt;
    logic [ADJ_CNT_W-1:0] adj_cnt_next;
    logic                 sec_inc_next;
    logic                 min_inc_next;
    logic                 running_next;
    logic                 blink_sec_next;
    logic                 blink_min_next;
    logic                 adj_entry;
    logic                 adj_next;

    // State, control registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RESET_STATE;
            pause_flag  <= PAUSE_ON_RESET;
            blink_phase <= 1'b0;
            adj_cnt     <= '0;
            sec_inc     <= 1'b0;
            min_inc     <= 1'b0;
            running     <= !PAUSE_ON_RESET;
            blink_sec   <= 1'b0;
            blink_min   <= 1'b0;
        end else begin
            state       <= state_next;
            pause_flag  <= pause_flag_next;
            blink_phase <= blink_phase_next;
            adj_cnt     <= adj_cnt_next;
            sec_inc     <= sec_inc_next;
            min_inc     <= min_inc_next;
            running     <= running_next;
            blink_sec   <= blink_sec_next;
            blink_min   <= blink_min_next;
        end
    end

    // Next-state and next-output logic; strobes act on the current state
    always_comb begin
        pause_flag_next  = pause_flag ^ pause_p;
        state_next       = ST_RUN;
        blink_phase_next = blink_phase;
        adj_cnt_next     = adj_cnt;
        sec_inc_next     = 1'b0;
        min_inc_next     = 1'b0;
        adj_entry        = 1'b0;
        adj_next         = 1'b0;
        running_next     = 1'b0;
        blink_sec_next   = 1'b0;
        blink_min_next   = 1'b0;

        // adj wins over the pause flag; the flag decides once adj drops
        if (adj) begin
            state_next = ST_ADJUST;
        end else if (pause_flag_next) begin
            state_next = ST_PAUSED;
        end

        case (state)
            ST_RUN: begin
                // Carry into minutes comes from the seconds field at its max
                if (tick_1hz) begin
                    sec_inc_next = 1'b1;
                    min_inc_next = sec_at_max;
                end
            end
            ST_ADJUST: begin
                // Divided 2 Hz stepping of the selected field, no carry
                if (tick_2hz) begin
                    blink_phase_next = ~blink_phase;
                    if (adj_cnt == ADJ_LAST) begin
                        adj_cnt_next = '0;
                        if (sel == SEL_SEC) begin
                            sec_inc_next = 1'b1;
                        end else begin
                            min_inc_next = 1'b1;
                        end
                    end else begin
                        adj_cnt_next = adj_cnt + ADJ_CNT_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase

        // Fresh divider and blink phase on every entry into ADJUST
        adj_entry = (state != ST_ADJUST) && (state_next == ST_ADJUST);
        if (adj_entry) begin
            adj_cnt_next     = '0;
            blink_phase_next = 1'b0;
        end

        adj_next       = (state_next == ST_ADJUST);
        running_next   = (state_next == ST_RUN);
        blink_sec_next = adj_next && (sel == SEL_SEC) && blink_phase_next;
        blink_min_next = adj_next && (sel == SEL_MIN) && blink_phase_next;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl. Two instances: one with
// default parameters, one with PAUSE_ON_RESET = 1 and ADJ_DIV = 3.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic reset, reset_p;
    logic tick_1hz, tick_2hz, pause_p, sel, adj, sec_at_max;
    logic sec_inc, min_inc, running, blink_sec, blink_min;
    logic p_sec_inc, p_min_inc, p_running, p_blink_sec, p_blink_min;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.ADJ_DIV(1), .PAUSE_ON_RESET(1'b0)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .pause_p(pause_p), .sel(sel), .adj(adj), .sec_at_max(sec_at_max),
        .sec_inc(sec_inc), .min_inc(min_inc), .running(running),
        .blink_sec(blink_sec), .blink_min(blink_min)
    );

    stopwatch_ctrl #(.ADJ_DIV(3), .PAUSE_ON_RESET(1'b1)) dut_p (
        .clk(clk), .reset(reset_p), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .pause_p(pause_p), .sel(sel), .adj(adj), .sec_at_max(sec_at_max),
        .sec_inc(p_sec_inc), .min_inc(p_min_inc), .running(p_running),
        .blink_sec(p_blink_sec), .blink_min(p_blink_min)
    );

    // One clock cycle with the given strobes; outputs are sampled 1 time unit after the edge
    task automatic cyc(input logic t1, input logic t2, input logic pp);
        tick_1hz = t1;
        tick_2hz = t2;
        pause_p  = pp;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        pause_p  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; reset_p = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        tests++; if (sec_inc !== 1'b0) begin fails++; $display("FAIL reset_sec_inc got=%b exp=0", sec_inc); end
        tests++; if (min_inc !== 1'b0) begin fails++; $display("FAIL reset_min_inc got=%b exp=0", min_inc); end
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL reset_running got=%b exp=1", running); end
        tests++; if ({blink_sec, blink_min} !== 2'b00) begin fails++; $display("FAIL reset_blink got=%b%b exp=00", blink_sec, blink_min); end
        tests++; if (p_running !== 1'b0) begin fails++; $display("FAIL reset_p_running got=%b exp=0", p_running); end
        reset = 1'b0; reset_p = 1'b0;
    endtask

    task automatic test_run_ticks();
        sec_at_max = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            tests++; if (sec_inc !== 1'b1) begin fails++; $display("FAIL run_tick%0d_sec_inc got=%b exp=1", i, sec_inc); end
            tests++; if (min_inc !== 1'b0) begin fails++; $display("FAIL run_tick%0d_min_inc got=%b exp=0", i, min_inc); end
            tests++; if (running !== 1'b1) begin fails++; $display("FAIL run_tick%0d_running got=%b exp=1", i, running); end
            cyc(1'b0, 1'b0, 1'b0);
            tests++; if (sec_inc !== 1'b0) begin fails++; $display("FAIL run_tick%0d_pulse_width got=%b exp=0", i, sec_inc); end
            cyc(1'b0, 1'b1, 1'b0);
            tests++; if ({sec_inc, min_inc} !== 2'b00) begin fails++; $display("FAIL run_2hz%0d_ignored got=%b%b exp=00", i, sec_inc, min_inc); end
        end
    endtask

    task automatic test_carry();
        sec_at_max = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        tests++; if ({sec_inc, min_inc} !== 2'b11) begin fails++; $display("FAIL carry_at_max got=%b%b exp=11", sec_inc, min_inc); end
        cyc(1'b0, 1'b0, 1'b0);
        tests++; if ({sec_inc, min_inc} !== 2'b00) begin fails++; $display("FAIL carry_no_tick got=%b%b exp=00", sec_inc, min_inc); end
        sec_at_max = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        tests++; if ({sec_inc, min_inc} !== 2'b10) begin fails++; $display("FAIL carry_not_max got=%b%b exp=10", sec_inc, min_inc); end
    endtask

    task automatic test_pause();
        cyc(1'b1, 1'b0, 1'b1);
        tests++; if (sec_inc !== 1'b1) begin fails++; $display("FAIL pause_tick_sec_inc got=%b exp=1", sec_inc); end
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL pause_running got=%b exp=0", running); end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            tests++; if ({sec_inc, min_inc} !== 2'b00) begin fails++; $display("FAIL paused_tick%0d got=%b%b exp=00", i, sec_inc, min_inc); end
        end
        cyc(1'b0, 1'b0, 1'b1);
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL unpause_running got=%b exp=1", running); end
        cyc(1'b1, 1'b0, 1'b0);
        tests++; if (sec_inc !== 1'b1) begin fails++; $display("FAIL unpause_tick got=%b exp=1", sec_inc); end
    endtask

    task automatic test_adjust_min();
        logic exp_blink;
        adj = 1'b1; sel = 1'b0;
        // tick_2hz in the entry cycle sees RUN and is ignored
        cyc(1'b0, 1'b1, 1'b0);
        tests++; if ({sec_inc, min_inc} !== 2'b00) begin fails++; $display("FAIL adj_entry_inc got=%b%b exp=00", sec_inc, min_inc); end
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL adj_entry_running got=%b exp=0", running); end
        tests++; if (blink_min !== 1'b0) begin fails++; $display("FAIL adj_entry_blink got=%b exp=0", blink_min); end
        for (int i = 0; i < 4; i++) begin
            exp_blink = ((i % 2) == 0);
            cyc(1'b0, 1'b1, 1'b0);
            tests++; if ({sec_inc, min_inc} !== 2'b01) begin fails++; $display("FAIL adj_min%0d_inc got=%b%b exp=01", i, sec_inc, min_inc); end
            tests++; if ({blink_sec, blink_min} !== {1'b0, exp_blink}) begin fails++; $display("FAIL adj_min%0d_blink got=%b%b exp=0%b", i, blink_sec, blink_min, exp_blink); end
            cyc(1'b1, 1'b0, 1'b0);
            tests++; if ({sec_inc, min_inc} !== 2'b00) begin fails++; $display("FAIL adj_min%0d_1hz_ignored got=%b%b exp=00", i, sec_inc, min_inc); end
            tests++; if (blink_min !== exp_blink) begin fails++; $display("FAIL adj_min%0d_blink_hold got=%b exp=%b", i, blink_min, exp_blink); end
        end
    endtask

    task automatic test_adjust_sec();
        sel = 1'b1; sec_at_max = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        tests++; if ({sec_inc, min_inc} !== 2'b10) begin fails++; $display("FAIL adj_sec_no_carry got=%b%b exp=10", sec_inc, min_inc); end
        tests++; if ({blink_sec, blink_min} !== 2'b10) begin fails++; $display("FAIL adj_sec_blink got=%b%b exp=10", blink_sec, blink_min); end
        cyc(1'b0, 1'b0, 1'b1);
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL adj_pause_running got=%b exp=0", running); end
        // tick_2hz coincident with adj falling still counts as ADJUST
        adj = 1'b0;
        cyc(1'b0, 1'b1, 1'b0);
        tests++; if ({sec_inc, min_inc} !== 2'b10) begin fails++; $display("FAIL adj_fall_tick got=%b%b exp=10", sec_inc, min_inc); end
        tests++; if ({running, blink_sec, blink_min} !== 3'b000) begin fails++; $display("FAIL adj_fall_paused got=%b%b%b exp=000", running, blink_sec, blink_min); end
        cyc(1'b1, 1'b0, 1'b0);
        tests++; if (sec_inc !== 1'b0) begin fails++; $display("FAIL adj_fall_paused_tick got=%b exp=0", sec_inc); end
        cyc(1'b0, 1'b0, 1'b1);
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL adj_resume got=%b exp=1", running); end
        sec_at_max = 1'b0;
    endtask

    task automatic test_adj_rise_tick();
        adj = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        tests++; if ({sec_inc, running} !== 2'b10) begin fails++; $display("FAIL adj_rise_tick got=%b%b exp=10", sec_inc, running); end
        adj = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        tests++; if ({sec_inc, running} !== 2'b01) begin fails++; $display("FAIL adj_rise_back got=%b%b exp=01", sec_inc, running); end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0, 1'b0);
        tests++; if (sec_inc !== 1'b1) begin fails++; $display("FAIL rmid_pre got=%b exp=1", sec_inc); end
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        tests++; if ({sec_inc, min_inc, running, blink_sec, blink_min} !== 5'b00100) begin fails++; $display("FAIL rmid_outputs got=%b%b%b%b%b exp=00100", sec_inc, min_inc, running, blink_sec, blink_min); end
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        tests++; if (running !== 1'b0) begin fails++; $display("FAIL rmid_paused got=%b exp=0", running); end
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        tests++; if (running !== 1'b1) begin fails++; $display("FAIL rmid_flag_clear got=%b exp=1", running); end
        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        tests++; if (sec_inc !== 1'b1) begin fails++; $display("FAIL rmid_post_tick got=%b exp=1", sec_inc); end
    endtask

    task automatic test_reset_paused();
        reset_p = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        tests++; if ({p_sec_inc, p_min_inc, p_running, p_blink_sec, p_blink_min} !== 5'b00000) begin fails++; $display("FAIL prst_outputs got=%b%b%b%b%b exp=00000", p_sec_inc, p_min_inc, p_running, p_blink_sec, p_blink_min); end
        reset_p = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            tests++; if ({p_sec_inc, p_min_inc, p_running} !== 3'b000) begin fails++; $display("FAIL prst_tick%0d got=%b%b%b exp=000", i, p_sec_inc, p_min_inc, p_running); end
        end
    endtask

    task automatic test_divider();
        logic exp_min;
        logic exp_blink;
        adj = 1'b1; sel = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            exp_min   = ((i % 3) == 2);
            exp_blink = ((i % 2) == 0);
            cyc(1'b0, 1'b1, 1'b0);
            tests++; if ({p_sec_inc, p_min_inc} !== {1'b0, exp_min}) begin fails++; $display("FAIL div%0d_inc got=%b%b exp=0%b", i, p_sec_inc, p_min_inc, exp_min); end
            tests++; if (p_blink_min !== exp_blink) begin fails++; $display("FAIL div%0d_blink got=%b exp=%b", i, p_blink_min, exp_blink); end
        end
        adj = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        tests++; if (p_running !== 1'b0) begin fails++; $display("FAIL div_exit_paused got=%b exp=0", p_running); end
        cyc(1'b0, 1'b0, 1'b1);
        tests++; if (p_running !== 1'b1) begin fails++; $display("FAIL div_unpause got=%b exp=1", p_running); end
        cyc(1'b1, 1'b0, 1'b0);
        tests++; if (p_sec_inc !== 1'b1) begin fails++; $display("FAIL div_run_tick got=%b exp=1", p_sec_inc); end
    endtask

    initial begin
        reset = 1'b1; reset_p = 1'b1;
        tick_1hz = 1'b0; tick_2hz = 1'b0; pause_p = 1'b0;
        sel = 1'b0; adj = 1'b0; sec_at_max = 1'b0;
        test_reset();
        test_run_ticks();
        test_carry();
        test_pause();
        test_adjust_min();
        test_adjust_sec();
        test_adj_rise_tick();
        test_reset_mid();
        test_reset_paused();
        test_divider();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
